// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master and its slave-side companions.
// State encoding, byte geometry and SPI mode constants.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_t;

  localparam int   SPI_BYTE_W = 8;
  localparam int   SPI_BIT_W  = $clog2(SPI_BYTE_W);
  localparam int   SPI_MODE   = 0;
  localparam logic SCLK_IDLE  = 1'b0;

endpackage

// File: rtl/spi_clk_tick.sv
// Half-period counter: runs 0..CLK_DIV-1 while enabled and flags the last count.
// Held at zero while disabled so every enabled run starts a full half-period.
module spi_clk_tick #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = $clog2(CLK_DIV) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_en || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one byte per START, MSB first, with CS setup/hold/gap framing.
// All outputs are registered; SCLK_PULSE strobes at each half-period end while active.
module spi_master
  import spi_pkg::*;
#(
  parameter  int CLK_DIV = 4,
  localparam int CNT_W   = $clog2(CLK_DIV) + 1
) (
  input  logic                  CTRL_CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [SPI_BYTE_W-1:0] TX_DATA,
  output logic [SPI_BYTE_W-1:0] RX_DATA,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  SCLK_PULSE,
  output logic                  CS,
  output logic                  SCLK,
  output logic                  SDO_M,
  input  logic                  SDI_M
);

  localparam logic [SPI_BIT_W-1:0] LAST_BIT = SPI_BIT_W'(SPI_BYTE_W - 1);

  spi_state_t            r_state;
  logic [SPI_BYTE_W-1:0] r_tx_shift;
  logic [SPI_BYTE_W-1:0] r_rx_shift;
  logic [SPI_BYTE_W-1:0] r_rx_data;
  logic [SPI_BIT_W-1:0]  r_bit_cnt;
  logic                  r_cs;
  logic                  r_sclk;
  logic                  r_sdo;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_sclk_pulse;

  logic w_cnt_en;
  logic w_tick;

  assign w_cnt_en = (r_state != ST_IDLE);

  spi_clk_tick #(
    .CLK_DIV(CLK_DIV),
    .CNT_W  (CNT_W)
  ) u_tick (
    .clk   (CTRL_CLK),
    .rst   (RST),
    .i_en  (w_cnt_en),
    .o_tick(w_tick)
  );

  // NOTE: every register, including the shift registers, is reset so an aborted transfer leaves no residue.
  always_ff @(posedge CTRL_CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_tx_shift   <= '0;
      r_rx_shift   <= '0;
      r_rx_data    <= '0;
      r_bit_cnt    <= '0;
      r_cs         <= 1'b1;
      r_sclk       <= SCLK_IDLE;
      r_sdo        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sclk_pulse <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      // The GAP tick lands in IDLE once registered, so it is suppressed to keep the strobe low there.
      r_sclk_pulse <= w_tick && (r_state != ST_GAP);

      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_tx_shift <= TX_DATA;
            r_sdo      <= TX_DATA[SPI_BYTE_W-1];
            r_cs       <= 1'b0;
            r_busy     <= 1'b1;
            r_bit_cnt  <= '0;
            r_state    <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (w_tick) r_state <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (w_tick) begin
            r_sclk <= ~r_sclk;
            if (!r_sclk) begin
              r_rx_shift <= {r_rx_shift[SPI_BYTE_W-2:0], SDI_M};
            end else if (r_bit_cnt != LAST_BIT) begin
              r_tx_shift <= {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
              r_sdo      <= r_tx_shift[SPI_BYTE_W-2];
              r_bit_cnt  <= r_bit_cnt + SPI_BIT_W'(1);
            end else begin
              r_state <= ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (w_tick) begin
            r_cs      <= 1'b1;
            r_rx_data <= r_rx_shift;
            r_done    <= 1'b1;
            r_sdo     <= 1'b0;
            r_state   <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (w_tick) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign RX_DATA    = r_rx_data;
  assign BUSY       = r_busy;
  assign DONE       = r_done;
  assign SCLK_PULSE = r_sclk_pulse;
  assign CS         = r_cs;
  assign SCLK       = r_sclk;
  assign SDO_M      = r_sdo;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: random bytes through loopback or a mode-0 slave model,
// plus collision, async reset, back-to-back and CLK_DIV=1 scenarios.
module tb_spi_master;

  localparam int DIV = 4;

  typedef struct {
    logic [7:0]  rx;
    logic [7:0]  cap;
    int unsigned done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT with CLK_DIV=4
  logic       start, busy, done, sclk_pulse, cs, sclk, sdo, sdi;
  logic [7:0] tx_data, rx_data;

  // DUT with CLK_DIV=1, always in loopback
  logic       start1, busy1, done1, pulse1, cs1, sclk1, sdo1;
  logic [7:0] tx1, rx1;

  spi_master #(.CLK_DIV(DIV)) dut (
    .CTRL_CLK(clk), .RST(rst), .START(start), .TX_DATA(tx_data), .RX_DATA(rx_data),
    .BUSY(busy), .DONE(done), .SCLK_PULSE(sclk_pulse), .CS(cs), .SCLK(sclk),
    .SDO_M(sdo), .SDI_M(sdi)
  );

  spi_master #(.CLK_DIV(1)) dut1 (
    .CTRL_CLK(clk), .RST(rst), .START(start1), .TX_DATA(tx1), .RX_DATA(rx1),
    .BUSY(busy1), .DONE(done1), .SCLK_PULSE(pulse1), .CS(cs1), .SCLK(sclk1),
    .SDO_M(sdo1), .SDI_M(sdo1)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Mode-0 slave model: drives its byte MSB first, advancing after each SCLK fall,
  // and captures MOSI on each SCLK rise.
  logic       loopback = 1'b1;
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] slave_cap = 8'h00;
  logic [2:0] sidx = 3'd0;
  int         rises = 0;
  time        t_cs = 0, t_rise = 0;

  assign sdi = loopback ? sdo : slave_byte[3'd7 - sidx];

  always @(negedge cs) begin
    sidx      = 3'd0;
    rises     = 0;
    slave_cap = 8'h00;
    t_cs      = $time;
  end

  always @(negedge sclk) if (!cs && sidx != 3'd7) sidx = sidx + 3'd1;

  always @(posedge sclk) begin
    if (!cs) begin
      if (rises == 0) t_rise = $time;
      slave_cap = {slave_cap[6:0], sdo};
      rises++;
    end
  end

  // Scoreboard monitor
  exp_t exp_q[$];

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rx_data", rx_data, e.rx);
        check("done_cycle", cyc, e.done_cyc);
        check("slave_captured", slave_cap, e.cap);
        check("sclk_rises", rises, 8);
        check("cs_to_sclk_setup", ((t_rise - t_cs) >= DIV * 10) ? 1 : 0, 1);
      end
    end
  end

  // Continuous protocol invariants, folded into one comparison at the end
  int unsigned viol = 0;
  int unsigned cs_run = 0;
  int unsigned last_cs_run = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (cs && sclk) viol++;
      if (!busy && (sclk_pulse || !cs)) viol++;
      if (cs) begin
        cs_run++;
      end else begin
        if (cs_run != 0) begin
          last_cs_run = cs_run;
          if (cs_run < DIV) viol++;
        end
        cs_run = 0;
      end
    end
  end

  task automatic xfer(input logic [7:0] tx, input logic [7:0] sb, input logic lb,
                      output int unsigned acc);
    int n = 0;
    while (busy && n < 40 * DIV) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("wait_idle_timeout", 1, 0);
    tx_data    = tx;
    slave_byte = sb;
    loopback   = lb;
    start      = 1'b1;
    acc        = cyc + 1;
    exp_q.push_back('{rx: (lb ? tx : sb), cap: tx, done_cyc: acc + 18 * DIV});
    @(negedge clk);
    start   = 1'b0;
    tx_data = 8'($urandom);
    check("cs_low_after_start", cs, 0);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_busy_low(input int unsigned acc);
    int n = 0;
    while (busy && n < 30 * DIV) begin
      @(negedge clk);
      n++;
    end
    check("busy_fall_cycle", cyc, acc + 19 * DIV);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int unsigned acc, acc2;
    logic [7:0]  t;

    rst = 1'b1; start = 1'b0; tx_data = 8'h00;
    start1 = 1'b0; tx1 = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_cs", cs, 1);
    check("reset_sclk", sclk, 0);
    check("reset_sdo", sdo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pulse", sclk_pulse, 0);
    check("reset_rx", rx_data, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Loopback 0xA5
    xfer(8'hA5, 8'h00, 1'b1, acc);
    wait_busy_low(acc);
    check("loopback_rx_hold", rx_data, 8'hA5);

    // Slave returns 0x3C while master sends 0xF0
    xfer(8'hF0, 8'h3C, 1'b0, acc);
    wait_busy_low(acc);
    check("slave_rx_hold", rx_data, 8'h3C);

    // START with 0x11 twenty cycles into a transfer is ignored
    t = 8'($urandom) | 8'h01;
    xfer(t, 8'h00, 1'b1, acc);
    repeat (20) @(negedge clk);
    tx_data = 8'h11;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_busy_low(acc);
    check("collision_rx", rx_data, t);

    // Async reset thirty cycles into a transfer
    xfer(8'($urandom), 8'($urandom), 1'b0, acc);
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_cs", cs, 1);
    check("abort_sclk", sclk, 0);
    check("abort_busy", busy, 0);
    check("abort_rx", rx_data, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    xfer(8'h69, 8'hC3, 1'b0, acc);
    wait_busy_low(acc);

    // START held high: 0x01 then 0x80
    repeat (3) @(negedge clk);
    tx_data  = 8'h01;
    loopback = 1'b1;
    start    = 1'b1;
    acc      = cyc + 1;
    acc2     = acc + 19 * DIV + 1;
    exp_q.push_back('{rx: 8'h01, cap: 8'h01, done_cyc: acc + 18 * DIV});
    exp_q.push_back('{rx: 8'h80, cap: 8'h80, done_cyc: acc2 + 18 * DIV});
    @(negedge clk);
    tx_data = 8'h80;
    repeat (19 * DIV + 1) @(negedge clk);
    check("b2b_second_busy", busy, 1);
    check("b2b_second_cs", cs, 0);
    check("b2b_cs_gap_ok", (last_cs_run >= DIV) ? 1 : 0, 1);
    start = 1'b0;
    wait_busy_low(acc2);

    // Randomised transfers against the reference model
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      xfer(8'($urandom), 8'($urandom), 1'($urandom), acc);
      wait_busy_low(acc);
    end

    // CLK_DIV=1 loopback of 0x5A
    begin
      int unsigned rise_cyc[$];
      int unsigned done_at = 0;
      logic        prev = 1'b0;
      tx1    = 8'h5A;
      start1 = 1'b1;
      acc    = cyc + 1;
      @(negedge clk);
      start1 = 1'b0;
      prev   = sclk1;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (done1 && done_at == 0) done_at = cyc;
        if (sclk1 && !prev) rise_cyc.push_back(cyc);
        prev = sclk1;
      end
      check("div1_rx", rx1, 8'h5A);
      check("div1_done_cycle", done_at, acc + 18);
      check("div1_busy_low", busy1, 0);
      check("div1_rises", rise_cyc.size(), 8);
      for (int k = 1; k < rise_cyc.size(); k++)
        check("div1_sclk_period", rise_cyc[k] - rise_cyc[k-1], 2);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("protocol_invariants", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
